myled_axil_slave: RTL and testbench
===================================

# myled_axil_slave

AXI4-Lite responder (slave) register file for the myLED peripheral: four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC, with register 0 driving the board LEDs. It sits behind the PS/interconnect master port and is the target exercised by the AXI4-Lite master VIP sequential write/read-back test.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; decode uses ADDR[3:2], ADDR[1:0] ignored.
- C_LED_WIDTH, 4: number of LED outputs, 1..32.

Ports:
- S_AXI_ACLK  in  1  single clock; all logic on rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables; bit n gates WDATA[8n+7:8n].
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- LED  out  C_LED_WIDTH  registered copy of slv_reg0[C_LED_WIDTH-1:0].

## Operation
- Registers slv_reg0..3, 32 bits each, reset to 0.
- Write path state: aw_full (address latched), w_full (data+strobe latched), BVALID.
- AWREADY = !aw_full && !BVALID; WREADY = !w_full && !BVALID. Combinational from state only, never from AWVALID/WVALID.
- AW and W accepted independently in any order, including the same cycle; each latched on its handshake edge.
- Commit: on the first edge where aw_full && w_full, write the strobed bytes into slv_reg[addr[3:2]], clear aw_full/w_full, set BVALID.
- BVALID held until the BREADY edge; no new AW/W accepted while BVALID=1 (one outstanding write).
- Read path: ARREADY = !RVALID. On AR handshake edge, RDATA <= slv_reg[ARADDR[3:2]], RVALID <= 1. RDATA and RVALID held stable until the RREADY edge.
- Read and write paths are fully independent; both may progress in the same cycle.
- Same-edge collision: an AR handshake on the edge of a write commit to the same register returns the pre-write value.
- LED updated one cycle after slv_reg0 changes.
- Reset (any cycle, including mid-transaction): all registers, LED, aw_full, w_full, BVALID, RVALID and RDATA go to 0; in-flight transactions are discarded without a response.

## Timing
- Reset values: AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, RDATA=0, BRESP=RRESP=0, LED=0 (READYs high from the first cycle after reset is released).
- Write latency: AW and W on the same edge N gives commit and BVALID=1 at edge N+1. B handshake at edge M gives READYs high again after M.
- Read latency: AR handshake at edge N gives RVALID=1 with data after N. With RREADY held high, back-to-back reads sustain one read per 2 cycles.
- The register value is visible to a read whose AR handshake occurs at or after edge N+2.

## Test plan
- Sequential: write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC with WSTRB=0xF, then read all four -> each BRESP=OKAY, reads return 0x1..0x4, LED=4'h1.
- Byte strobes: write 0xAABBCCDD to 0x4, then 0x11223344 with WSTRB=0x5 -> read 0x4 returns 0xAA22CC44.
- Ordering: present W(0xDEADBEEF) 3 cycles before AW(0x8), then AW before W at 0xC -> both BVALID exactly once; reads return the written values.
- Backpressure: hold BREADY=0 for 5 cycles after a write, RREADY=0 for 5 cycles after a read of 0x0 -> BVALID/RVALID/RDATA stay stable; AWREADY=WREADY=0 and ARREADY=0 throughout.
- Collision: commit write 0x55 to 0x0 on the same edge as an AR handshake to 0x0 (old value 0x1) -> RDATA=0x1; the next read returns 0x55.
- Reset mid-op: assert S_AXI_ARESET with BVALID=1 and RVALID=1 -> next cycle all valids=0, READYs=1, all registers read 0, LED=0.

Source files
------------

// File: rtl/myled_axil_slave.sv
// myled_axil_slave: AXI4-Lite register file, four 32-bit regs, reg0 drives LEDs.
// Ports: S_AXI_* AXI4-Lite slave channels (AW/W/B/AR/R), LED out from slv_reg0.
module myled_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int C_LED_WIDTH        = 4
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_LED_WIDTH-1:0]          LED
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int NB = DW / 8;

   logic          aw_full;
   logic          w_full;
   logic          bvalid;
   logic          rvalid;
   logic [1:0]    aw_idx;
   logic [DW-1:0] w_data;
   logic [NB-1:0] w_strb;
   logic [DW-1:0] rdata;
   logic [DW-1:0] slv_reg [4];
   logic [C_LED_WIDTH-1:0] led;

   logic aw_hs;
   logic w_hs;
   logic ar_hs;
   logic commit;

   // Readies depend on state only, so the master never sees a
   // combinational path from its own VALIDs back to READY.
   assign S_AXI_AWREADY = !aw_full && !bvalid;
   assign S_AXI_WREADY  = !w_full && !bvalid;
   assign S_AXI_ARREADY = !rvalid;

   assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign commit = aw_full && w_full;

   assign S_AXI_BRESP  = 2'b00;
   assign S_AXI_RRESP  = 2'b00;
   assign S_AXI_BVALID = bvalid;
   assign S_AXI_RVALID = rvalid;
   assign S_AXI_RDATA  = rdata;
   assign LED          = led;

   // Write channel capture and response.
   // Readies are low while a half is held or B is pending, so a new
   // handshake can never coincide with the commit clearing the flags.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         bvalid  <= 1'b0;
         aw_idx  <= '0;
         w_data  <= '0;
         w_strb  <= '0;
      end else begin
         if (aw_hs) begin
            aw_full <= 1'b1;
            aw_idx  <= S_AXI_AWADDR[3:2];
         end
         if (w_hs) begin
            w_full <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bvalid  <= 1'b1;
         end else if (bvalid && S_AXI_BREADY) begin
            bvalid <= 1'b0;
         end
      end
   end

   // Register file with byte-lane strobes.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         for (int i = 0; i < 4; i++) begin
            slv_reg[i] <= '0;
         end
      end else if (commit) begin
         for (int b = 0; b < NB; b++) begin
            if (w_strb[b]) begin
               slv_reg[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
            end
         end
      end
   end

   // Read channel. Sampling slv_reg here sees the pre-commit value
   // when a write lands on the same edge.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rdata  <= slv_reg[S_AXI_ARADDR[3:2]];
      end else if (rvalid && S_AXI_RREADY) begin
         rvalid <= 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         led <= '0;
      end else begin
         led <= slv_reg[0][C_LED_WIDTH-1:0];
      end
   end

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_myled_axil_slave.sv
// tb_myled_axil_slave: scoreboard bench for myled_axil_slave.
// Drives AXI4-Lite writes/reads, compares B/R results against a queue model.
module tb_myled_axil_slave;

   logic        clk;
   logic        rst;
   logic [3:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [3:0]  led;

   int n_tests = 0;
   int n_fail  = 0;
   int b_cnt   = 0;

   logic [31:0] model [4];
   logic [1:0]  b_q [$];
   logic [31:0] r_q [$];

   myled_axil_slave dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .S_AXI_AWADDR (awaddr),
      .S_AXI_AWPROT (awprot),
      .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA  (wdata),
      .S_AXI_WSTRB  (wstrb),
      .S_AXI_WVALID (wvalid),
      .S_AXI_WREADY (wready),
      .S_AXI_BRESP  (bresp),
      .S_AXI_BVALID (bvalid),
      .S_AXI_BREADY (bready),
      .S_AXI_ARADDR (araddr),
      .S_AXI_ARPROT (arprot),
      .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA  (rdata),
      .S_AXI_RRESP  (rresp),
      .S_AXI_RVALID (rvalid),
      .S_AXI_RREADY (rready),
      .LED          (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && bvalid && bready) b_cnt <= b_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_wr(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      for (int b = 0; b < 4; b++) begin
         if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   task automatic wait_hs(input string tag);
      int t = 0;
      while (!((!wvalid || wready) && (!awvalid || awready)) && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) chk(tag, 32'(t), 32'd0);
   endtask

   // mode 0: AW+W together; 1: W then AW 3 cycles later; 2: AW then W.
   task automatic wr(input logic [3:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int mode, input int hold);
      int t;
      int bc0;
      bc0 = b_cnt;
      model_wr(a, d, s);
      b_q.push_back(2'b00);
      @(negedge clk);
      if (mode != 2) begin
         wdata = d; wstrb = s; wvalid = 1'b1;
      end
      if (mode != 1) begin
         awaddr = a; awvalid = 1'b1;
      end
      wait_hs("wr_tmo1");
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      if (mode != 0) begin
         repeat (3) @(negedge clk);
         chk("b_early", 32'(bvalid), 32'd0);
         if (mode == 1) begin
            awaddr = a; awvalid = 1'b1;
         end else begin
            wdata = d; wstrb = s; wvalid = 1'b1;
         end
         wait_hs("wr_tmo2");
         @(negedge clk);
         awvalid = 1'b0;
         wvalid  = 1'b0;
      end
      t = 0;
      while (!bvalid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("b_lat", 32'(t), 32'd1);
      if (b_q.size() != 0) chk("bresp", 32'(bresp), 32'(b_q.pop_front()));
      else chk("b_q_empty", 32'd0, 32'd1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("b_hold_v", 32'(bvalid), 32'd1);
         chk("b_hold_awr", 32'(awready), 32'd0);
         chk("b_hold_wr", 32'(wready), 32'd0);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("b_done", 32'(bvalid), 32'd0);
      chk("b_once", 32'(b_cnt - bc0), 32'd1);
      chk("rdy_back", 32'({awready, wready}), 32'd3);
   endtask

   task automatic rd(input logic [3:0] a, input int hold,
                     output logic [31:0] obs);
      int t;
      logic [31:0] exp;
      @(negedge clk);
      araddr  = a;
      arvalid = 1'b1;
      r_q.push_back(model[a[3:2]]);
      t = 0;
      while (!arready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) chk("ar_tmo", 32'(t), 32'd0);
      @(negedge clk);
      arvalid = 1'b0;
      t = 0;
      while (!rvalid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("r_lat", 32'(t), 32'd0);
      obs = rdata;
      exp = (r_q.size() != 0) ? r_q.pop_front() : 32'hxxxxxxxx;
      chk("rdata", rdata, exp);
      chk("rresp", 32'(rresp), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("r_hold_v", 32'(rvalid), 32'd1);
         chk("r_hold_d", rdata, exp);
         chk("r_hold_ar", 32'(arready), 32'd0);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      chk("r_done", 32'(rvalid), 32'd0);
      chk("ar_back", 32'(arready), 32'd1);
   endtask

   logic [31:0] obs;

   initial begin
      rst = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_awready", 32'(awready), 32'd1);
      chk("rst_wready", 32'(wready), 32'd1);
      chk("rst_arready", 32'(arready), 32'd1);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_resp", 32'({bresp, rresp}), 32'd0);
      chk("rst_led", 32'(led), 32'd0);

      for (int i = 0; i < 4; i++) wr(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
      for (int i = 0; i < 4; i++) begin
         rd(4'(i * 4), 0, obs);
         chk("seq_val", obs, 32'(i + 1));
      end
      chk("seq_led", 32'(led), 32'h1);

      wr(4'h4, 32'hAABBCCDD, 4'hF, 0, 0);
      wr(4'h4, 32'h11223344, 4'h5, 0, 0);
      rd(4'h4, 0, obs);
      chk("strb_val", obs, 32'hAA22CC44);

      wr(4'h8, 32'hDEADBEEF, 4'hF, 1, 0);
      wr(4'hC, 32'h0BADF00D, 4'hF, 2, 0);
      rd(4'h8, 0, obs);
      chk("ord_w_first", obs, 32'hDEADBEEF);
      rd(4'hC, 0, obs);
      chk("ord_aw_first", obs, 32'h0BADF00D);

      wr(4'hC, 32'h12345678, 4'hF, 0, 5);
      rd(4'h0, 5, obs);

      // Collision: AW/W handshake at edge N, AR at N+1 = commit edge.
      @(negedge clk);
      awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 4'h0; arvalid = 1'b1;
      r_q.push_back(model[0]);
      b_q.push_back(2'b00);
      model_wr(4'h0, 32'h55, 4'hF);
      @(negedge clk);
      arvalid = 1'b0;
      chk("col_bvalid", 32'(bvalid), 32'd1);
      chk("col_rvalid", 32'(rvalid), 32'd1);
      chk("col_rdata", rdata, r_q.pop_front());
      chk("col_old", rdata, 32'h1);
      chk("col_bresp", 32'(bresp), 32'(b_q.pop_front()));
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      rd(4'h0, 0, obs);
      chk("col_new", obs, 32'h55);
      chk("col_led", 32'(led), 32'h5);

      // Reset with both a B and an R response pending.
      @(negedge clk);
      awaddr = 4'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      araddr = 4'h8; arvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge clk);
      chk("pre_rst_b", 32'(bvalid), 32'd1);
      chk("pre_rst_r", 32'(rvalid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;
      b_q.delete();
      r_q.delete();
      chk("mr_bvalid", 32'(bvalid), 32'd0);
      chk("mr_rvalid", 32'(rvalid), 32'd0);
      chk("mr_rdata", rdata, 32'd0);
      chk("mr_ready", 32'({awready, wready, arready}), 32'd7);
      chk("mr_led", 32'(led), 32'd0);
      for (int i = 0; i < 4; i++) begin
         rd(4'(i * 4), 0, obs);
         chk("mr_reg", obs, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
